// File: rtl/spi2dac_pkg.sv
// Shared types and frame layout for the MCP4911 serialiser.
// The frame is {/WR, BUF, /GA, /SHDN, D9..D0, x, x}, sent MSB first.
package spi2dac_pkg;

   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned WR_BIT   = 15;
   localparam int unsigned BUF_BIT  = 14;
   localparam int unsigned GA_BIT   = 13;
   localparam int unsigned SHDN_BIT = 12;
   localparam int unsigned DATA_MSB = 11;
   localparam int unsigned DATA_LSB = 2;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap,
      StLatch
   } state_e;

   function automatic logic [FRAME_W-1:0] build_frame(input logic       vref_buf,
                                                      input logic       ga_n,
                                                      input logic       shdn_n,
                                                      input logic [9:0] data);
      logic [FRAME_W-1:0] f;
      f                    = '0;
      f[WR_BIT]            = 1'b0;
      f[BUF_BIT]           = vref_buf;
      f[GA_BIT]            = ga_n;
      f[SHDN_BIT]          = shdn_n;
      f[DATA_MSB:DATA_LSB] = data;
      return f;
   endfunction

endpackage

// File: rtl/spi2dac_stream_phase_tick.sv
// Phase timer: counts CLK_DIV sysclk cycles and pulses phase_end_o on the last one.
// Holding clear_i restarts the phase so the first pulse comes CLK_DIV cycles after release.
module spi_phase_tick #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic clear_i,
   output logic phase_end_o
);

   localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - 8'd1;
      if (clear_i || (cnt_q == 8'd0)) begin
         cnt_d = Reload;
      end
   end

   assign phase_end_o = (cnt_q == 8'd0) && !clear_i;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi2dac_stream.sv
// Serialises one 10-bit sample per load strobe into an MCP4911 frame, then pulses LDAC.
// Every output is a register; the phase timer paces SCK halves, the gap and the latch pulse.
module spi2dac_stream
   import spi2dac_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 25,
   parameter logic        DAC_BUF    = 1'b0,
   parameter logic        DAC_GA_N   = 1'b1,
   parameter logic        DAC_SHDN_N = 1'b1
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [9:0] data_in,
   input  logic       load,
   output logic       dac_cs_n,
   output logic       dac_sck,
   output logic       dac_sdi,
   output logic       dac_ld_n,
   output logic       busy,
   output logic       overrun
);

   state_e               state_q, state_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic [3:0]           bit_q, bit_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sck_q, sck_d;
   logic                 sdi_q, sdi_d;
   logic                 ld_n_q, ld_n_d;
   logic                 busy_q, busy_d;
   logic                 overrun_q, overrun_d;
   logic                 phase_end;
   logic [FRAME_W-1:0]   frame;

   assign frame = build_frame(DAC_BUF, DAC_GA_N, DAC_SHDN_N, data_in);

   spi_phase_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_phase_tick (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .clear_i    (state_q == StIdle),
      .phase_end_o(phase_end)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_d     = bit_q;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      sdi_d     = sdi_q;
      ld_n_d    = ld_n_q;
      busy_d    = busy_q;
      overrun_d = overrun_q | (load && (state_q != StIdle));

      unique case (state_q)
         StIdle: begin
            if (load) begin
               shreg_d = frame;
               sdi_d   = frame[WR_BIT];
               bit_d   = 4'd15;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (phase_end) begin
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else if (bit_q == 4'd0) begin
                  sck_d   = 1'b0;
                  cs_n_d  = 1'b1;
                  sdi_d   = 1'b0;
                  state_d = StGap;
               end else begin
                  // Falling SCK: next bit appears here so it is stable at the next rise.
                  sck_d   = 1'b0;
                  shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                  sdi_d   = shreg_q[FRAME_W-2];
                  bit_d   = bit_q - 4'd1;
               end
            end
         end
         StGap: begin
            if (phase_end) begin
               ld_n_d  = 1'b0;
               state_d = StLatch;
            end
         end
         StLatch: begin
            if (phase_end) begin
               ld_n_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         bit_q     <= 4'd0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         sdi_q     <= 1'b0;
         ld_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_q     <= bit_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         sdi_q     <= sdi_d;
         ld_n_q    <= ld_n_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign dac_cs_n = cs_n_q;
   assign dac_sck  = sck_q;
   assign dac_sdi  = sdi_q;
   assign dac_ld_n = ld_n_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi2dac_stream.sv
// Bench for spi2dac_stream: instance A (CLK_DIV=25, BUF=1) and instance B (CLK_DIV=2, defaults).
// Monitors rebuild each SPI word from rising SCK edges and compare it with a queued expectation.
module tb_spi2dac_stream;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   always #5 sysclk = ~sysclk;

   logic [9:0] data_a = '0, data_b = '0;
   logic       load_a = 1'b0, load_b = 1'b0;
   logic       cs_a, sck_a, sdi_a, ld_a, busy_a, ovr_a;
   logic       cs_b, sck_b, sdi_b, ld_b, busy_b, ovr_b;

   spi2dac_stream #(
      .CLK_DIV(25),
      .DAC_BUF(1'b1)
   ) dut_a (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .data_in (data_a),
      .load    (load_a),
      .dac_cs_n(cs_a),
      .dac_sck (sck_a),
      .dac_sdi (sdi_a),
      .dac_ld_n(ld_a),
      .busy    (busy_a),
      .overrun (ovr_a)
   );

   spi2dac_stream #(
      .CLK_DIV(2)
   ) dut_b (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .data_in (data_b),
      .load    (load_b),
      .dac_cs_n(cs_b),
      .dac_sck (sck_b),
      .dac_sdi (sdi_b),
      .dac_ld_n(ld_b),
      .busy    (busy_b),
      .overrun (ovr_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   logic [15:0] q_a[$];
   logic [15:0] q_b[$];

   initial begin : mon_a
      logic [15:0] sh;
      int          nb;
      logic        psck;
      sh = '0; nb = 0; psck = 1'b0;
      forever begin
         @(negedge sysclk);
         if (!rst_n) begin
            nb = 0; psck = 1'b0;
         end else begin
            if (!cs_a && sck_a && !psck) begin
               sh = {sh[14:0], sdi_a};
               nb++;
            end
            if (cs_a && nb != 0) begin
               if (q_a.size() == 0) check("word_a_unexpected", 32'(sh), 32'hFFFF_FFFF);
               else check("word_a", 32'(sh), 32'(q_a.pop_front()));
               check("bits_a", nb, 16);
               nb = 0;
            end
            psck = sck_a;
         end
      end
   end

   initial begin : mon_b
      logic [15:0] sh;
      int          nb;
      logic        psck;
      sh = '0; nb = 0; psck = 1'b0;
      forever begin
         @(negedge sysclk);
         if (!rst_n) begin
            nb = 0; psck = 1'b0;
         end else begin
            if (!cs_b && sck_b && !psck) begin
               sh = {sh[14:0], sdi_b};
               nb++;
            end
            if (cs_b && nb != 0) begin
               if (q_b.size() == 0) check("word_b_unexpected", 32'(sh), 32'hFFFF_FFFF);
               else check("word_b", 32'(sh), 32'(q_b.pop_front()));
               check("bits_b", nb, 16);
               nb = 0;
            end
            psck = sck_b;
         end
      end
   end

   // Issues one frame on A at a negedge and follows it until busy drops (first idle cycle).
   task automatic frame_a(input logic [9:0] d, input logic [15:0] exp);
      int busy_n, cs_rise, ld_start, ld_cnt;
      busy_n = 0; cs_rise = -1; ld_start = -1; ld_cnt = 0;
      q_a.push_back(exp);
      data_a = d; load_a = 1'b1;
      @(negedge sysclk);
      load_a = 1'b0;
      for (int i = 1; i <= 2000; i++) begin
         if (!busy_a) break;
         busy_n++;
         if (cs_a && cs_rise < 0) cs_rise = i;
         if (!ld_a) begin
            ld_cnt++;
            if (ld_start < 0) ld_start = i;
         end
         @(negedge sysclk);
      end
      if (busy_a) check("busy_timeout_a", 32'd1, 32'd0);
      check("busy_len_a", busy_n, 850);
      check("ld_len_a", ld_cnt, 25);
      check("cs_to_ld_a", ld_start - cs_rise, 25);
      check("sb_drained_a", q_a.size(), 0);
   endtask

   typedef struct {
      logic [9:0]  data;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int busy_n, r1, r2, ld_seen;
      logic psck;

      vecs[0] = '{data: 10'h2A5, exp: 16'h7A94};
      vecs[1] = '{data: 10'h000, exp: 16'h7000};
      vecs[2] = '{data: 10'h3FF, exp: 16'h7FFC};
      vecs[3] = '{data: 10'h155, exp: 16'h7554};

      repeat (3) @(negedge sysclk);
      check("rst_cs_n", 32'(cs_a), 32'd1);
      check("rst_sck", 32'(sck_a), 32'd0);
      check("rst_sdi", 32'(sdi_a), 32'd0);
      check("rst_ld_n", 32'(ld_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_overrun", 32'(ovr_a), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge sysclk);

      for (int v = 0; v < 4; v++) begin
         frame_a(vecs[v].data, vecs[v].exp);
         check("no_overrun_table", 32'(ovr_a), 32'd0);
         repeat (3) @(negedge sysclk);
      end

      // Back-to-back: second load lands on the first idle cycle.
      frame_a(10'h0F0, 16'h73C0);
      frame_a(10'h30F, 16'h7C3C);
      check("b2b_overrun", 32'(ovr_a), 32'd0);

      // Instance B: CLK_DIV=2, default BUF=0, data_in scrambled every cycle after the load edge.
      q_b.push_back(16'h370C);
      data_b = 10'h1C3; load_b = 1'b1;
      @(negedge sysclk);
      load_b = 1'b0;
      busy_n = 0; r1 = -1; r2 = -1; psck = sck_b;
      for (int i = 1; i <= 500; i++) begin
         if (!busy_b) break;
         busy_n++;
         if (sck_b && !psck) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
         psck   = sck_b;
         data_b = 10'($urandom);
         @(negedge sysclk);
      end
      check("busy_len_b", busy_n, 68);
      check("sck_period_b", r2 - r1, 4);
      check("sb_drained_b", q_b.size(), 0);

      // Overrun: second load 200 cycles into the frame is ignored but flagged.
      repeat (2) @(negedge sysclk);
      q_a.push_back(16'h7294);
      data_a = 10'h0A5; load_a = 1'b1;
      @(negedge sysclk);
      load_a = 1'b0;
      repeat (199) @(negedge sysclk);
      data_a = 10'h3FF; load_a = 1'b1;
      @(negedge sysclk);
      load_a = 1'b0;
      for (int i = 0; i < 2000 && busy_a; i++) @(negedge sysclk);
      check("ovr_set", 32'(ovr_a), 32'd1);
      check("ovr_frame_intact", q_a.size(), 0);
      repeat (2) @(negedge sysclk);
      frame_a(10'h000, 16'h7000);
      check("ovr_sticky", 32'(ovr_a), 32'd1);

      // Reset at cycle 100 of a frame: immediate idle outputs and no LDAC afterwards.
      repeat (2) @(negedge sysclk);
      q_a.push_back(16'h7554);
      data_a = 10'h155; load_a = 1'b1;
      @(negedge sysclk);
      load_a = 1'b0;
      repeat (99) @(negedge sysclk);
      check("mid_busy_before", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_cs_n", 32'(cs_a), 32'd1);
      check("mid_ld_n", 32'(ld_a), 32'd1);
      check("mid_sck", 32'(sck_a), 32'd0);
      check("mid_busy", 32'(busy_a), 32'd0);
      check("mid_overrun", 32'(ovr_a), 32'd0);
      q_a.delete();
      @(negedge sysclk);
      rst_n = 1'b1;
      ld_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge sysclk);
         if (!ld_a || busy_a) ld_seen++;
      end
      check("mid_no_latch", ld_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi2dac_stream.md
Name: spi2dac_stream

Overview:
- Downstream stage of the echo processor: takes the 10-bit offset-binary sample the processor presents on its data_out bus and serialises it to the external MCP4911 10-bit SPI DAC.
- One frame per tick_10k strobe.
- Generates its own SCK from sysclk, drives chip select and the LDAC latch pulse.
- Reports busy and a sticky overrun flag.

Parameters:
- CLK_DIV, 25, sysclk cycles per SCK half-period (50 MHz sysclk gives 1 MHz SCK); legal range 2..255.
- DAC_BUF, 1'b0, MCP4911 VREF buffer bit (frame bit 14).
- DAC_GA_N, 1'b1, gain select, 1 = 1x (frame bit 13).
- DAC_SHDN_N, 1'b1, active-low shutdown, 1 = output active (frame bit 12).

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  10  offset-binary sample from the processor's data_out.
- load  in  1  one-sysclk-wide strobe (tick_10k) requesting a new frame.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sck  out  1  SPI clock.
- dac_sdi  out  1  SPI data to DAC, MSB first.
- dac_ld_n  out  1  DAC LDAC, active low.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: load arrived while busy.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1, busy=0, overrun=0, divider and bit counters =0.
- Frame word (16 bits, captured on the accepting edge): {1'b0, DAC_BUF, DAC_GA_N, DAC_SHDN_N, data_in[9:0], 2'b00}.
- States: IDLE -> SHIFT -> GAP -> LATCH -> IDLE.
- IDLE:
  - On load=1: capture the frame into the shift register, go to SHIFT, zero the divider, set bit count=15.
  - busy, dac_cs_n=0 and dac_sdi=bit15 all take effect on the cycle after the load edge.
- SHIFT: each bit is CLK_DIV cycles with dac_sck=0, then CLK_DIV cycles with dac_sck=1.
  - dac_sdi changes only at the start of a low phase (falling SCK or CS assertion), so it is stable across the rising edge.
  - After the high phase of bit 0: dac_sck=0, dac_cs_n=1, go to GAP.
  - SHIFT lasts 32*CLK_DIV cycles; exactly 16 rising SCK edges occur with dac_cs_n=0.
- GAP: CLK_DIV cycles, CS high, LDAC high, SCK low.
- LATCH: dac_ld_n=0 for CLK_DIV cycles, then IDLE with dac_ld_n=1 and busy=0.
- busy is high for exactly 34*CLK_DIV cycles per frame (850 at default).
- dac_sdi returns to 0 when dac_cs_n deasserts.
- load while busy: ignored, the frame in flight is not disturbed, overrun<=1. overrun is cleared only by reset.
- load on the same cycle busy falls (first IDLE cycle): accepted normally.
- data_in is sampled only on the accepting edge; later changes do not affect the frame in flight.
- rst_n asserted mid-frame: immediate return to reset values, with CS and LDAC high; no partial latch is issued.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package spi2dac_pkg holds:
  - the state enum (IDLE, SHIFT, GAP, LATCH);
  - frame-bit position constants (WR_BIT=15, BUF_BIT=14, GA_BIT=13, SHDN_BIT=12, DATA_MSB=11, DATA_LSB=2);
  - the frame width constant 16.
- One sub-module: spi_phase_tick, a CLK_DIV down-counter with sync clear that emits a one-cycle phase_end pulse. The FSM uses it for every phase.

Test Plan:
- Reset mid-frame: pulse load with data_in=10'h155, then assert rst_n low at cycle 100 → outputs immediately cs_n=1, ld_n=1, sck=0, busy=0; no LDAC pulse follows.
- Single frame, CLK_DIV=25, data_in=10'h2A5 → SDI bits sampled on the 16 rising SCK edges = 16'h7A94. busy high for 850 cycles. ld_n low for 25 cycles, starting 25 cycles after cs_n rises.
- Extremes: data_in=10'h000 → 16'h7000; data_in=10'h3FF → 16'h7FFC.
- Overrun: load, second load 200 cycles later with data_in=10'h3FF → first frame completes unchanged, overrun=1 and stays 1 across the next normal frame.
- Back-to-back: load on the first cycle after busy falls → accepted, busy rises the next cycle, overrun stays 0.
- Data stability: change data_in every cycle during SHIFT → transmitted word equals the value present on the load edge; at CLK_DIV=2, SCK period = 4 sysclk and busy = 68 cycles.
